// File: rtl/calc_arb_pkg.sv
// Shared types and constants for the calculator command arbiter.
package calc_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4
    } arb_state_e;

    localparam int unsigned SEL_BITS     = 4;
    localparam int unsigned DIN_BITS     = 32;
    localparam int unsigned BW_CNT_BITS  = 8;
    localparam int unsigned TMO_CNT_BITS = 16;

endpackage

// File: rtl/calc_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    grant_any
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] cand;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDX_W'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = wrap_idx(ptr, i);
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_cmd_arbiter.sv
// Round-robin sharing of one BinaryCalculator among NREQ requesters, with divider config sequencing.
// Optional busy watchdog enabled by defining CALC_ARB_TIMEOUT_EN.
module calc_cmd_arbiter
    import calc_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned INBITS    = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUSY_WAIT = 4,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [NREQ-1:0]              ReqValid,
    input  logic [NREQ-1:0]              ReqRW,
    input  logic [NREQ-1:0]              ReqInputKey,
    input  logic [NREQ*INBITS-1:0]       ReqInA,
    input  logic [NREQ*INBITS-1:0]       ReqInB,
    input  logic [NREQ*WIDTH-1:0]        ReqAddr,
    input  logic [NREQ*SEL_BITS-1:0]     ReqSel,
    input  logic [NREQ*DIN_BITS-1:0]     ReqDin,
    output logic [NREQ-1:0]              ReqGrant,
    output logic [NREQ-1:0]              ReqDone,
    input  logic                         CfgValid,
    input  logic [DIN_BITS-1:0]          CfgDiv,
    output logic                         CfgDone,
    output logic                         ValidCmd,
    output logic                         RW,
    output logic                         InputKey,
    output logic                         ConfigDiv,
    output logic [INBITS-1:0]            InA,
    output logic [INBITS-1:0]            InB,
    output logic [WIDTH-1:0]             Addr,
    output logic [SEL_BITS-1:0]          Sel,
    output logic [DIN_BITS-1:0]          Din,
    input  logic                         CalcBusy,
    output logic [$clog2(NREQ)-1:0]      Owner,
    output logic                         ErrTimeout
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || BUSY_WAIT < 1 || TIMEOUT < 1) begin : g_param_check
        $error("calc_cmd_arbiter: parameter out of range");
    end

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [BW_CNT_BITS-1:0]   bw_cnt_q, bw_cnt_d;
    logic                     busy_early_q, busy_early_d;
    logic                     valid_cmd_q, valid_cmd_d;
    logic [NREQ-1:0]          grant_q, grant_d;
    logic [NREQ-1:0]          done_q, done_d;
    logic                     cfg_done_q, cfg_done_d;
    logic                     config_div_q, config_div_d;
    logic                     rw_q, rw_d;
    logic                     key_q, key_d;
    logic [INBITS-1:0]        in_a_q, in_a_d;
    logic [INBITS-1:0]        in_b_q, in_b_d;
    logic [WIDTH-1:0]         addr_q, addr_d;
    logic [SEL_BITS-1:0]      sel_q, sel_d;
    logic [DIN_BITS-1:0]      din_q, din_d;
`ifdef CALC_ARB_TIMEOUT_EN
    logic [TMO_CNT_BITS-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic                     err_q, err_d;
`endif

    logic [NREQ-1:0]          arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_any;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req       (ReqValid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Outputs are registered, so pulses and fields are set on the transition into their state.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        bw_cnt_d     = bw_cnt_q;
        busy_early_d = 1'b0;
        valid_cmd_d  = 1'b0;
        grant_d      = '0;
        done_d       = '0;
        cfg_done_d   = 1'b0;
        config_div_d = 1'b0;
        rw_d         = rw_q;
        key_d        = key_q;
        in_a_d       = in_a_q;
        in_b_d       = in_b_q;
        addr_d       = addr_q;
        sel_d        = sel_q;
        din_d        = din_q;
`ifdef CALC_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (CfgValid) begin
                    state_d      = ST_CFG;
                    config_div_d = 1'b1;
                    cfg_done_d   = 1'b1;
                    din_d        = CfgDiv;
                end else if (arb_any) begin
                    state_d     = ST_ISSUE;
                    valid_cmd_d = 1'b1;
                    grant_d     = arb_grant;
                    owner_d     = arb_idx;
                    ptr_d       = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    rw_d        = ReqRW[arb_idx];
                    key_d       = ReqInputKey[arb_idx];
                    in_a_d      = ReqInA[arb_idx*INBITS +: INBITS];
                    in_b_d      = ReqInB[arb_idx*INBITS +: INBITS];
                    addr_d      = ReqAddr[arb_idx*WIDTH +: WIDTH];
                    sel_d       = ReqSel[arb_idx*SEL_BITS +: SEL_BITS];
                    din_d       = ReqDin[arb_idx*DIN_BITS +: DIN_BITS];
                end
            end
            ST_CFG: begin
                state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                state_d      = ST_WAIT_RISE;
                bw_cnt_d     = '0;
                busy_early_d = CalcBusy;
            end
            ST_WAIT_RISE: begin
                if (CalcBusy || busy_early_q) begin
                    state_d = ST_WAIT_FALL;
`ifdef CALC_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else if (bw_cnt_q == BW_CNT_BITS'(BUSY_WAIT - 1)) begin
                    state_d         = ST_IDLE;
                    done_d[owner_q] = 1'b1;
                end else begin
                    bw_cnt_d = bw_cnt_q + 1'b1;
                end
            end
            ST_WAIT_FALL: begin
                if (!CalcBusy) begin
                    state_d         = ST_IDLE;
                    done_d[owner_q] = 1'b1;
                end
`ifdef CALC_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_CNT_BITS'(TIMEOUT - 1)) begin
                    state_d         = ST_IDLE;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            bw_cnt_q     <= '0;
            busy_early_q <= 1'b0;
            valid_cmd_q  <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
            cfg_done_q   <= 1'b0;
            config_div_q <= 1'b0;
            rw_q         <= 1'b0;
            key_q        <= 1'b0;
            in_a_q       <= '0;
            in_b_q       <= '0;
            addr_q       <= '0;
            sel_q        <= '0;
            din_q        <= '0;
`ifdef CALC_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            bw_cnt_q     <= bw_cnt_d;
            busy_early_q <= busy_early_d;
            valid_cmd_q  <= valid_cmd_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            cfg_done_q   <= cfg_done_d;
            config_div_q <= config_div_d;
            rw_q         <= rw_d;
            key_q        <= key_d;
            in_a_q       <= in_a_d;
            in_b_q       <= in_b_d;
            addr_q       <= addr_d;
            sel_q        <= sel_d;
            din_q        <= din_d;
`ifdef CALC_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign ReqGrant  = grant_q;
    assign ReqDone   = done_q;
    assign CfgDone   = cfg_done_q;
    assign ValidCmd  = valid_cmd_q;
    assign RW        = rw_q;
    assign InputKey  = key_q;
    assign ConfigDiv = config_div_q;
    assign InA       = in_a_q;
    assign InB       = in_b_q;
    assign Addr      = addr_q;
    assign Sel       = sel_q;
    assign Din       = din_q;
    assign Owner     = owner_q;
`ifdef CALC_ARB_TIMEOUT_EN
    assign ErrTimeout = err_q;
`else
    assign ErrTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Directed self-checking bench for calc_cmd_arbiter (NREQ=4, BUSY_WAIT=4, TIMEOUT=16).
module tb_calc_cmd_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned INBITS    = 8;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned BUSY_WAIT = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic [NREQ-1:0]        ReqValid, ReqRW, ReqInputKey;
    logic [NREQ*INBITS-1:0] ReqInA, ReqInB;
    logic [NREQ*WIDTH-1:0]  ReqAddr;
    logic [NREQ*4-1:0]      ReqSel;
    logic [NREQ*32-1:0]     ReqDin;
    logic [NREQ-1:0]        ReqGrant, ReqDone;
    logic                   CfgValid;
    logic [31:0]            CfgDiv;
    logic                   CfgDone;
    logic                   ValidCmd, RW, InputKey, ConfigDiv;
    logic [INBITS-1:0]      InA, InB;
    logic [WIDTH-1:0]       Addr;
    logic [3:0]             Sel;
    logic [31:0]            Din;
    logic                   CalcBusy;
    logic [1:0]             Owner;
    logic                   ErrTimeout;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    calc_cmd_arbiter #(
        .NREQ      (NREQ),
        .INBITS    (INBITS),
        .WIDTH     (WIDTH),
        .BUSY_WAIT (BUSY_WAIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqRW       (ReqRW),
        .ReqInputKey (ReqInputKey),
        .ReqInA      (ReqInA),
        .ReqInB      (ReqInB),
        .ReqAddr     (ReqAddr),
        .ReqSel      (ReqSel),
        .ReqDin      (ReqDin),
        .ReqGrant    (ReqGrant),
        .ReqDone     (ReqDone),
        .CfgValid    (CfgValid),
        .CfgDiv      (CfgDiv),
        .CfgDone     (CfgDone),
        .ValidCmd    (ValidCmd),
        .RW          (RW),
        .InputKey    (InputKey),
        .ConfigDiv   (ConfigDiv),
        .InA         (InA),
        .InB         (InB),
        .Addr        (Addr),
        .Sel         (Sel),
        .Din         (Din),
        .CalcBusy    (CalcBusy),
        .Owner       (Owner),
        .ErrTimeout  (ErrTimeout)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({ValidCmd, ConfigDiv, CfgDone, RW, InputKey, ErrTimeout} !== 6'b0 || ReqGrant !== 4'b0 ||
            ReqDone !== 4'b0 || Owner !== 2'd0 || InA !== 8'h0 || InB !== 8'h0 || Addr !== 8'h0 ||
            Sel !== 4'h0 || Din !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ValidCmd=%0b Grant=%b Done=%b Owner=%0d InA=%h Din=%h, want all zero",
                     ValidCmd, ReqGrant, ReqDone, Owner, InA, Din);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (ValidCmd !== 1'b0 || CfgDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ValidCmd=%0b CfgDone=%0b, want 0 0", ValidCmd, CfgDone);
        end
    endtask

    task automatic test_cfg();
        CfgValid = 1'b1;
        CfgDiv   = 32'd3;
        tick();
        checks++;
        if (ConfigDiv !== 1'b1 || CfgDone !== 1'b1 || Din !== 32'd3 || ValidCmd !== 1'b0) begin
            errors++;
            $display("FAIL cfg_pulse: ConfigDiv=%0b CfgDone=%0b Din=%h ValidCmd=%0b, want 1 1 3 0",
                     ConfigDiv, CfgDone, Din, ValidCmd);
        end
        CfgValid = 1'b0;
        tick();
        checks++;
        if (ConfigDiv !== 1'b0 || CfgDone !== 1'b0 || Din !== 32'd3) begin
            errors++;
            $display("FAIL cfg_end: ConfigDiv=%0b CfgDone=%0b Din=%h, want 0 0 3", ConfigDiv, CfgDone, Din);
        end
        tick();
        checks++;
        if (ValidCmd !== 1'b0 || CfgDone !== 1'b0) begin
            errors++;
            $display("FAIL cfg_no_repeat: ValidCmd=%0b CfgDone=%0b, want 0 0", ValidCmd, CfgDone);
        end
    endtask

    task automatic test_two_req();
        int bad;
        ReqValid = 4'b0101;
        tick();
        checks++;
        if (ValidCmd !== 1'b1 || ReqGrant !== 4'b0001 || Owner !== 2'd0 || InA !== 8'h10 ||
            Addr !== 8'h30 || Din !== 32'hD000_0000 || RW !== 1'b0) begin
            errors++;
            $display("FAIL two_issue0: ValidCmd=%0b Grant=%b Owner=%0d InA=%h Addr=%h Din=%h RW=%0b, want 1 0001 0 10 30 d0000000 0",
                     ValidCmd, ReqGrant, Owner, InA, Addr, Din, RW);
        end
        ReqValid = 4'b0100;
        CalcBusy = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ValidCmd !== 1'b0 || ReqGrant !== 4'b0 || ReqDone !== 4'b0) bad++;
        end
        CalcBusy = 1'b0;
        tick();
        checks++;
        if (bad != 0 || ReqDone !== 4'b0001 || ValidCmd !== 1'b0) begin
            errors++;
            $display("FAIL two_done0: early=%0d Done=%b ValidCmd=%0b, want 0 0001 0", bad, ReqDone, ValidCmd);
        end
        tick();
        checks++;
        if (ValidCmd !== 1'b1 || ReqGrant !== 4'b0100 || Owner !== 2'd2 || InA !== 8'h12 ||
            InB !== 8'h22 || Sel !== 4'd3 || InputKey !== 1'b1) begin
            errors++;
            $display("FAIL two_issue2: ValidCmd=%0b Grant=%b Owner=%0d InA=%h InB=%h Sel=%0d Key=%0b, want 1 0100 2 12 22 3 1",
                     ValidCmd, ReqGrant, Owner, InA, InB, Sel, InputKey);
        end
        ReqValid = 4'b0000;
        CalcBusy = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ReqDone !== 4'b0) bad++;
        end
        CalcBusy = 1'b0;
        tick();
        checks++;
        if (bad != 0 || ReqDone !== 4'b0100 || Owner !== 2'd2) begin
            errors++;
            $display("FAIL two_done2: early=%0d Done=%b Owner=%0d, want 0 0100 2", bad, ReqDone, Owner);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        logic [3:0] seen;
        Reset    = 1'b1;
        ReqValid = 4'b1111;
        tick();
        Reset = 1'b0;
        tick();
        seen = 4'b0;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            if (k < 4) seen = seen | ReqGrant;
            checks++;
            if (ValidCmd !== 1'b1 || ReqGrant !== exp || Owner !== 2'(k % 4) || InA !== 8'(8'h10 + k % 4)) begin
                errors++;
                $display("FAIL rr_grant%0d: ValidCmd=%0b Grant=%b Owner=%0d InA=%h, want 1 %b %0d %h",
                         k, ValidCmd, ReqGrant, Owner, InA, exp, k % 4, 8'(8'h10 + k % 4));
            end
            CalcBusy = 1'b1;
            tick();
            tick();
            CalcBusy = 1'b0;
            tick();
            checks++;
            if (ReqDone !== exp) begin
                errors++;
                $display("FAIL rr_done%0d: Done=%b, want %b", k, ReqDone, exp);
            end
            if (k == 4) ReqValid = 4'b0000;
            tick();
        end
        checks++;
        if (seen !== 4'b1111 || ValidCmd !== 1'b0) begin
            errors++;
            $display("FAIL rr_fairness: first-four grants=%b ValidCmd=%0b, want 1111 0", seen, ValidCmd);
        end
    endtask

    task automatic test_busy_wait();
        int         seen;
        logic [3:0] done_val;
        ReqValid = 4'b1000;
        tick();
        checks++;
        if (ValidCmd !== 1'b1 || ReqGrant !== 4'b1000 || RW !== 1'b1 || Owner !== 2'd3) begin
            errors++;
            $display("FAIL bw_issue: ValidCmd=%0b Grant=%b RW=%0b Owner=%0d, want 1 1000 1 3",
                     ValidCmd, ReqGrant, RW, Owner);
        end
        ReqValid = 4'b0000;
        tick();
        seen     = 0;
        done_val = 4'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ReqDone !== 4'b0 && seen == 0) begin
                seen     = c;
                done_val = ReqDone;
            end
        end
        checks++;
        if (seen != int'(BUSY_WAIT) || done_val !== 4'b1000) begin
            errors++;
            $display("FAIL bw_done: after %0d cycles Done=%b, want %0d cycles 1000 (0 = never)",
                     seen, done_val, BUSY_WAIT);
        end
    endtask

    task automatic test_cfg_priority();
        ReqValid = 4'b0001;
        tick();
        checks++;
        if (ValidCmd !== 1'b1 || ReqGrant !== 4'b0001) begin
            errors++;
            $display("FAIL pri_issue0: ValidCmd=%0b Grant=%b, want 1 0001", ValidCmd, ReqGrant);
        end
        ReqValid = 4'b0000;
        CalcBusy = 1'b1;
        tick();
        tick();
        CfgValid = 1'b1;
        CfgDiv   = 32'h55;
        ReqValid = 4'b0010;
        tick();
        checks++;
        if (ValidCmd !== 1'b0 || CfgDone !== 1'b0 || ConfigDiv !== 1'b0) begin
            errors++;
            $display("FAIL pri_hold: ValidCmd=%0b CfgDone=%0b ConfigDiv=%0b, want 0 0 0", ValidCmd, CfgDone, ConfigDiv);
        end
        CalcBusy = 1'b0;
        tick();
        checks++;
        if (ReqDone !== 4'b0001 || CfgDone !== 1'b0) begin
            errors++;
            $display("FAIL pri_done0: Done=%b CfgDone=%0b, want 0001 0", ReqDone, CfgDone);
        end
        tick();
        checks++;
        if (CfgDone !== 1'b1 || ConfigDiv !== 1'b1 || Din !== 32'h55 || ValidCmd !== 1'b0 ||
            ReqGrant !== 4'b0 || InA !== 8'h10) begin
            errors++;
            $display("FAIL pri_cfg: CfgDone=%0b ConfigDiv=%0b Din=%h ValidCmd=%0b Grant=%b InA=%h, want 1 1 55 0 0000 10",
                     CfgDone, ConfigDiv, Din, ValidCmd, ReqGrant, InA);
        end
        CfgValid = 1'b0;
        tick();
        checks++;
        if (CfgDone !== 1'b0 || ValidCmd !== 1'b0) begin
            errors++;
            $display("FAIL pri_gap: CfgDone=%0b ValidCmd=%0b, want 0 0", CfgDone, ValidCmd);
        end
        tick();
        checks++;
        if (ValidCmd !== 1'b1 || ReqGrant !== 4'b0010 || Din !== 32'hD000_0001 || InA !== 8'h11 || ConfigDiv !== 1'b0) begin
            errors++;
            $display("FAIL pri_issue1: ValidCmd=%0b Grant=%b Din=%h InA=%h ConfigDiv=%0b, want 1 0010 d0000001 11 0",
                     ValidCmd, ReqGrant, Din, InA, ConfigDiv);
        end
        ReqValid = 4'b0000;
        repeat (BUSY_WAIT + 1) tick();
        checks++;
        if (ReqDone !== 4'b0010) begin
            errors++;
            $display("FAIL pri_done1: Done=%b, want 0010", ReqDone);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        ReqValid = 4'b0100;
        tick();
        ReqValid = 4'b0000;
        CalcBusy = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        checks++;
        if ({ValidCmd, ConfigDiv, CfgDone, RW, InputKey, ErrTimeout} !== 6'b0 || ReqGrant !== 4'b0 ||
            ReqDone !== 4'b0 || Owner !== 2'd0 || InA !== 8'h0 || Sel !== 4'h0 || Din !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: ValidCmd=%0b Done=%b Owner=%0d InA=%h Sel=%0d Din=%h, want all zero",
                     ValidCmd, ReqDone, Owner, InA, Sel, Din);
        end
        Reset    = 1'b0;
        CalcBusy = 1'b0;
        bad      = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ReqDone !== 4'b0 || ValidCmd !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_silent: %0d cycles with Done/ValidCmd after reset, want 0", bad);
        end
    endtask

    task automatic test_timeout();
`ifdef CALC_ARB_TIMEOUT_EN
        int         seen;
        logic [3:0] done_val;
        ReqValid = 4'b0010;
        tick();
        ReqValid = 4'b0000;
        CalcBusy = 1'b1;
        tick();
        tick();
        seen     = 0;
        done_val = 4'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ReqDone !== 4'b0 && seen == 0) begin
                seen     = c;
                done_val = ReqDone;
            end
        end
        checks++;
        if (seen != int'(TIMEOUT) || done_val !== 4'b0010 || ErrTimeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_done: after %0d cycles Done=%b Err=%0b, want %0d 0010 1",
                     seen, done_val, ErrTimeout, TIMEOUT);
        end
        CalcBusy = 1'b0;
        tick();
        checks++;
        if (ErrTimeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: Err=%0b, want 1", ErrTimeout);
        end
`else
        checks++;
        if (ErrTimeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_tied: Err=%0b, want 0", ErrTimeout);
        end
`endif
    endtask

    initial begin
        Reset       = 1'b1;
        ReqValid    = '0;
        CfgValid    = 1'b0;
        CfgDiv      = '0;
        CalcBusy    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ReqRW[i]              = i[0];
            ReqInputKey[i]        = i[1];
            ReqInA[i*8 +: 8]      = 8'(8'h10 + i);
            ReqInB[i*8 +: 8]      = 8'(8'h20 + i);
            ReqAddr[i*8 +: 8]     = 8'(8'h30 + i);
            ReqSel[i*4 +: 4]      = 4'(i + 1);
            ReqDin[i*32 +: 32]    = 32'hD000_0000 + 32'(i);
        end
        test_reset();
        test_cfg();
        test_two_req();
        test_round_robin();
        test_busy_wait();
        test_cfg_priority();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_cmd_arbiter.md
Name: calc_cmd_arbiter

Overview:
Shares one BinaryCalculator between NREQ requesters. Arbitrates round-robin, issues each command as a one-cycle ValidCmd pulse with that requester's fields, and tracks CalcBusy until the command completes. Also sequences clock-divider configuration (ConfigDiv) ahead of queued commands. Sits between the requester fabric and the BinaryCalculator instance.

Parameters:
NREQ, 4, number of requesters (2..8)
INBITS, 8, operand width (InA/InB)
WIDTH, 8, address width (Addr)
BUSY_WAIT, 4, cycles to wait for CalcBusy rise before treating a command as done
TIMEOUT, 1023, max cycles CalcBusy may stay high (optional feature only)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
ReqValid  in  NREQ  per-requester command request, level, held until ReqGrant
ReqRW  in  NREQ  per-requester RW
ReqInputKey  in  NREQ  per-requester InputKey level
ReqInA / ReqInB  in  NREQ*INBITS  packed operands, requester i at [i*INBITS +: INBITS]
ReqAddr  in  NREQ*WIDTH  packed addresses
ReqSel  in  NREQ*4  packed Sel
ReqDin  in  NREQ*32  packed Din
ReqGrant  out  NREQ  one-hot, one-cycle pulse: command accepted
ReqDone  out  NREQ  one-hot, one-cycle pulse: command finished
CfgValid  in  1  divider-config request, held until CfgDone
CfgDiv  in  32  divider value
CfgDone  out  1  one-cycle pulse
ValidCmd, RW, InputKey, ConfigDiv  out  1  to calculator
InA, InB  out  INBITS; Addr  out  WIDTH; Sel  out  4; Din  out  32  to calculator
CalcBusy  in  1  from calculator
Owner  out  $clog2(NREQ)  index of current/last granted requester
ErrTimeout  out  1  sticky watchdog flag

Behaviour:
- One clock Clk; Reset synchronous, active-high. All outputs registered.
- Reset: state IDLE, all outputs 0, RR pointer 0, ErrTimeout 0. Reset mid-command aborts silently: no ReqDone, requester must re-request.
- States: IDLE, CFG, ISSUE, WAIT_RISE, WAIT_FALL.
- IDLE: CfgValid has absolute priority -> CFG. Else any ReqValid -> ISSUE with winner = first set bit at or after RR pointer (wrapping). Nothing pending -> stay.
- CFG (1 cycle): ConfigDiv=1, Din=CfgDiv, CfgDone=1 -> IDLE. No busy wait.
- ISSUE (1 cycle): ValidCmd=1, ReqGrant[winner]=1, command fields loaded from winner, Owner=winner, RR pointer = winner+1 mod NREQ -> WAIT_RISE. Latency ReqValid-sampled-in-IDLE to ValidCmd = 1 cycle.
- Command fields (RW, InputKey, InA, InB, Addr, Sel, Din) hold until next ISSUE/CFG; CFG changes only Din.
- WAIT_RISE: CalcBusy=1 -> WAIT_FALL; BUSY_WAIT cycles without rise -> ReqDone[Owner] pulse, IDLE.
- WAIT_FALL: CalcBusy=0 -> ReqDone[Owner] pulse, IDLE.
- CalcBusy already high in ISSUE cycle: counts as rise in first WAIT_RISE cycle.
- ReqValid dropped before grant: request withdrawn, no grant. CfgValid during a command: served at next IDLE, before pending requests.
- Back-to-back: min 1 IDLE cycle between ReqDone and next ValidCmd.

Optional Feature:
CALC_ARB_TIMEOUT_EN. Defined: counter in WAIT_FALL; CalcBusy high for TIMEOUT cycles -> ErrTimeout=1 (sticky until Reset), ReqDone[Owner] pulse, IDLE. Undefined: WAIT_FALL waits indefinitely, ErrTimeout tied 0, no counter logic.

Decomposition:
- Package calc_arb_pkg: state enum, SEL_BITS=4, DIN_BITS=32, counter width constants.
- Sub-module rr_arbiter (NREQ): combinational first-set-from-pointer search returning one-hot grant and index; pointer register stays in parent.

Test Plan:
- Reset, CfgValid=1 CfgDiv=3 -> one cycle later ConfigDiv=1, Din=3, CfgDone pulse; no ValidCmd.
- ReqValid=4'b0101 held, CalcBusy high 5 cycles per command -> grants req0 then req2, ValidCmd 1 cycle each, ReqDone after each CalcBusy fall, Owner 0 then 2.
- All 4 requesting continuously -> grant order 0,1,2,3,0; no requester granted twice within 4 grants.
- Write command, CalcBusy never rises -> ReqDone exactly BUSY_WAIT cycles after WAIT_RISE entry.
- CfgValid raised during WAIT_FALL with ReqValid=4'b0010 pending -> CFG served before req1 ISSUE.
- Reset pulsed in WAIT_FALL -> all outputs 0 next cycle, no ReqDone; with CALC_ARB_TIMEOUT_EN, TIMEOUT=16, CalcBusy stuck high -> ErrTimeout=1 and ReqDone at cycle 16.
